// File: rtl/inst_sram_port_arbiter_if.sv
// inst_sram_port_arbiter_if: req/gnt/rvalid SRAM-style bus between a requester (master) and a responder (slave)
interface inst_sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic req, gnt, we, rvalid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0] wdata, rdata;
    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_sram_port_arbiter.sv
// inst_sram_port_arbiter: fair two-requester arbiter for the instruction SRAM with in-flight owner tracking
// INST_ARB_QOS_EN selects core priority with a starvation limit instead of round-robin.
module inst_sram_port_arbiter #(
    parameter int MAX_OUTST = 2
`ifdef INST_ARB_QOS_EN
    , parameter int STARVE_LIM = 8
`endif
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    inst_sram_port_arbiter_if.slave         m0,
    inst_sram_port_arbiter_if.slave         m1,
    inst_sram_port_arbiter_if.master        mem,
    output logic                            err_o
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    logic [CW-1:0] count_q, count_d, widx;
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic sel, sel_q, lock_q, hs, pop, room, tie_pick;
`ifdef INST_ARB_QOS_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    logic [SW-1:0] starve_q;
    assign tie_pick = starve_q == SW'(STARVE_LIM);
    always_ff @(posedge clk_i) begin
        if (reset_i || m1.gnt)
            starve_q <= '0;
        else if (m1.req && starve_q != SW'(STARVE_LIM))
            starve_q <= starve_q + SW'(1);
    end
`else
    logic rr_last_q;
    assign tie_pick = ~rr_last_q;
    always_ff @(posedge clk_i) begin
        if (reset_i)
            rr_last_q <= 1'b1;
        else if (hs)
            rr_last_q <= sel;
    end
`endif
    // A stalled request keeps its owner so the SRAM sees stable fields until granted
    assign sel = lock_q ? sel_q : (m0.req && m1.req) ? tie_pick : m1.req;
    assign room = count_q < CW'(MAX_OUTST);
    assign mem.req = ~reset_i & (sel ? m1.req : m0.req) & room;
    assign mem.addr = sel ? m1.addr : m0.addr;
    assign mem.we = sel ? m1.we : m0.we;
    assign mem.be = sel ? m1.be : m0.be;
    assign mem.wdata = sel ? m1.wdata : m0.wdata;
    assign hs = mem.req & mem.gnt;
    assign m0.gnt = hs & ~sel;
    assign m1.gnt = hs & sel;
    assign pop = ~reset_i & mem.rvalid & (count_q != '0);
    assign err_o = ~reset_i & mem.rvalid & (count_q == '0);
    assign m0.rvalid = pop & ~owner_q[0];
    assign m1.rvalid = pop & owner_q[0];
    assign m0.rdata = mem.rdata;
    assign m1.rdata = mem.rdata;
    // Owner FIFO as a shift register: head at bit 0, new owner lands just past the surviving entries
    always_comb begin
        widx = count_q - CW'(pop);
        owner_d = pop ? owner_q >> 1 : owner_q;
        for (int i = 0; i < MAX_OUTST; i++)
            if (hs && widx == CW'(i)) owner_d[i] = sel;
        count_d = count_q + CW'(hs) - CW'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            owner_q <= '0;
            lock_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            count_q <= count_d;
            owner_q <= owner_d;
            lock_q <= mem.req & ~mem.gnt;
            sel_q <= sel;
        end
    end
endmodule

// File: tb/tb_inst_sram_port_arbiter.sv
// tb_inst_sram_port_arbiter: scoreboard bench for inst_sram_port_arbiter (define INST_ARB_QOS_EN for the QoS build)
module tb_inst_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset_i;
    logic err_o;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic own;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    inst_sram_port_arbiter_if m0();
    inst_sram_port_arbiter_if m1();
    inst_sram_port_arbiter_if mem();

    inst_sram_port_arbiter dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .m0(m0),
        .m1(m1),
        .mem(mem),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        m0.req = 1'b1;
        m1.req = 1'b1;
        mem.gnt = 1'b1;
        mem.rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem.req !== 1'b0 || m0.gnt !== 1'b0 || m1.gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_req cyc%0d: mem_req=%b gnt0=%b gnt1=%b, want 0 0 0", c, mem.req, m0.gnt, m1.gnt);
            end
            checks++;
            if (m0.rvalid !== 1'b0 || m1.rvalid !== 1'b0 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp cyc%0d: rvalid0=%b rvalid1=%b err=%b, want 0 0 0", c, m0.rvalid, m1.rvalid, err_o);
            end
            tick();
        end
        m0.req = 1'b0;
        m1.req = 1'b0;
        mem.gnt = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_rr();
        exp_t e, p;
        logic want;
        m0.req = 1'b1;
        m1.req = 1'b1;
        m0.addr = 32'h100;
        m1.addr = 32'h200;
        m0.we = 1'b0;
        m1.we = 1'b1;
        m0.be = 4'h3;
        m1.be = 4'hF;
        mem.gnt = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) begin
                m0.req = 1'b0;
                m1.req = 1'b0;
            end
            mem.rvalid = exp_q.size() > 0;
            mem.rdata = exp_q.size() > 0 ? exp_q[0].data : '0;
            @(negedge clk);
            if (c < 8) begin
                want = c[0];
                checks++;
                if (m0.gnt !== !want || m1.gnt !== want || mem.addr !== (want ? 32'h200 : 32'h100)
                    || mem.we !== want || mem.be !== (want ? 4'hF : 4'h3)) begin
                    errors++;
                    $display("FAIL rr_grant cyc%0d: gnt0=%b gnt1=%b addr=%h we=%b be=%h, want owner %0d", c, m0.gnt, m1.gnt, mem.addr, mem.we, mem.be, want);
                end
                p.own = want;
                p.data = 32'hA000_0000 + c;
                exp_q.push_back(p);
            end
            if (mem.rvalid) begin
                e = exp_q.pop_front();
                checks++;
                if (m0.rvalid !== !e.own || m1.rvalid !== e.own || m0.rdata !== e.data || m1.rdata !== e.data) begin
                    errors++;
                    $display("FAIL rr_resp cyc%0d: rvalid0=%b rvalid1=%b rdata=%h, want owner %0d data %h", c, m0.rvalid, m1.rvalid, m0.rdata, e.own, e.data);
                end
            end
            tick();
        end
        mem.rvalid = 1'b0;
        mem.gnt = 1'b0;
    endtask

    task automatic test_stall();
        exp_t e, p;
        logic g0, g1;
        logic [31:0] wa;
        m0.addr = 32'h80;
        m1.addr = 32'h40;
        for (int c = 0; c < 7; c++) begin
            m1.req = c < 5;
            m0.req = c >= 2 && c < 6;
            mem.gnt = c >= 4;
            mem.rvalid = exp_q.size() > 0;
            mem.rdata = exp_q.size() > 0 ? exp_q[0].data : '0;
            @(negedge clk);
            g1 = c == 4;
            g0 = c == 5;
            wa = c < 5 ? 32'h40 : 32'h80;
            checks++;
            if (m0.gnt !== g0 || m1.gnt !== g1 || (c < 6 ? (mem.req !== 1'b1 || mem.addr !== wa) : mem.req !== 1'b0)) begin
                errors++;
                $display("FAIL stall cyc%0d: req=%b addr=%h gnt0=%b gnt1=%b, want req=%b addr=%h gnt0=%b gnt1=%b", c, mem.req, mem.addr, m0.gnt, m1.gnt, c < 6, wa, g0, g1);
            end
            if (g0 || g1) begin
                p.own = g1;
                p.data = 32'hB000_0000 + c;
                exp_q.push_back(p);
            end
            if (mem.rvalid) begin
                e = exp_q.pop_front();
                checks++;
                if (m0.rvalid !== !e.own || m1.rvalid !== e.own || m0.rdata !== e.data) begin
                    errors++;
                    $display("FAIL stall_resp cyc%0d: rvalid0=%b rvalid1=%b rdata=%h, want owner %0d data %h", c, m0.rvalid, m1.rvalid, m0.rdata, e.own, e.data);
                end
            end
            tick();
        end
        mem.rvalid = 1'b0;
        mem.gnt = 1'b0;
    endtask

    task automatic test_full();
        exp_t e, p;
        logic [6:0] rv = 7'b1101000;
        logic [6:0] mreq = 7'b0010011;
        logic [6:0] g1 = 7'b0010001;
        logic [6:0] g0 = 7'b0000010;
        m0.addr = 32'h100;
        m1.addr = 32'h200;
        mem.gnt = 1'b1;
        for (int c = 0; c < 7; c++) begin
            m0.req = c < 5;
            m1.req = c < 5;
            mem.rvalid = rv[c];
            mem.rdata = exp_q.size() > 0 ? exp_q[0].data : '0;
            @(negedge clk);
            checks++;
            if (mem.req !== mreq[c] || m0.gnt !== g0[c] || m1.gnt !== g1[c]) begin
                errors++;
                $display("FAIL full cyc%0d: req=%b gnt0=%b gnt1=%b, want %b %b %b", c, mem.req, m0.gnt, m1.gnt, mreq[c], g0[c], g1[c]);
            end
            if (g0[c] || g1[c]) begin
                p.own = g1[c];
                p.data = 32'hC000_0000 + c;
                exp_q.push_back(p);
            end
            if (rv[c]) begin
                e = exp_q.pop_front();
                checks++;
                if (m0.rvalid !== !e.own || m1.rvalid !== e.own || m0.rdata !== e.data) begin
                    errors++;
                    $display("FAIL full_resp cyc%0d: rvalid0=%b rvalid1=%b rdata=%h, want owner %0d data %h", c, m0.rvalid, m1.rvalid, m0.rdata, e.own, e.data);
                end
            end
            tick();
        end
        mem.rvalid = 1'b0;
        mem.gnt = 1'b0;
    endtask

    task automatic test_orphan();
        for (int c = 0; c < 2; c++) begin
            mem.rvalid = c == 0;
            mem.rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++;
            if (err_o !== (c == 0) || m0.rvalid !== 1'b0 || m1.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL orphan cyc%0d: err=%b rvalid0=%b rvalid1=%b, want err=%b rvalids 0", c, err_o, m0.rvalid, m1.rvalid, c == 0);
            end
            tick();
        end
        mem.rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        m0.req = 1'b1;
        m0.addr = 32'h300;
        mem.gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (m0.gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: gnt0=%b, want 1", m0.gnt);
        end
        tick();
        m0.req = 1'b0;
        mem.gnt = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        mem.rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || m0.rvalid !== 1'b0 || m1.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_late: err=%b rvalid0=%b rvalid1=%b, want 1 0 0", err_o, m0.rvalid, m1.rvalid);
        end
        tick();
        mem.rvalid = 1'b0;
    endtask

`ifdef INST_ARB_QOS_EN
    task automatic test_qos();
        exp_t e, p;
        logic want;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        m0.req = 1'b1;
        m1.req = 1'b1;
        m0.addr = 32'h100;
        m1.addr = 32'h200;
        mem.gnt = 1'b1;
        for (int c = 0; c < 19; c++) begin
            if (c == 18) begin
                m0.req = 1'b0;
                m1.req = 1'b0;
            end
            mem.rvalid = exp_q.size() > 0;
            mem.rdata = exp_q.size() > 0 ? exp_q[0].data : '0;
            @(negedge clk);
            if (c < 18) begin
                want = c == 8 || c == 17;
                checks++;
                if (m0.gnt !== !want || m1.gnt !== want) begin
                    errors++;
                    $display("FAIL qos_grant cyc%0d: gnt0=%b gnt1=%b, want owner %0d", c, m0.gnt, m1.gnt, want);
                end
                p.own = want;
                p.data = 32'hE000_0000 + c;
                exp_q.push_back(p);
            end
            if (mem.rvalid) begin
                e = exp_q.pop_front();
                checks++;
                if (m0.rvalid !== !e.own || m1.rvalid !== e.own || m0.rdata !== e.data) begin
                    errors++;
                    $display("FAIL qos_resp cyc%0d: rvalid0=%b rvalid1=%b rdata=%h, want owner %0d data %h", c, m0.rvalid, m1.rvalid, m0.rdata, e.own, e.data);
                end
            end
            tick();
        end
        mem.rvalid = 1'b0;
        mem.gnt = 1'b0;
    endtask
`endif

    initial begin
        m0.req = 1'b0; m0.addr = '0; m0.we = 1'b0; m0.be = '0; m0.wdata = 32'h1111_0000;
        m1.req = 1'b0; m1.addr = '0; m1.we = 1'b0; m1.be = '0; m1.wdata = 32'h2222_0000;
        mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
        reset_i = 1'b1;
        test_reset();
`ifndef INST_ARB_QOS_EN
        test_rr();
`endif
        test_stall();
`ifndef INST_ARB_QOS_EN
        test_full();
`endif
        test_orphan();
        test_reset_mid();
`ifdef INST_ARB_QOS_EN
        test_qos();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
